// File: rtl/xmpl_dsp_msf_pkg.sv
// Shared types and constants for the multi-channel moving-sum filter.
package xmpl_dsp_msf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD  = 2'd1,
        OUT  = 2'd2
    } msf_state_e;

    // Bit positions inside the status word
    localparam int FULL_LSB = 0;
    localparam int CNT_LSB  = 16;
    localparam int CNT_W    = 8;
    localparam int BUSY_BIT = 31;

    // True when v is a power of two (and non-zero)
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/xmpl_dsp_msf_win_ram.sv
// Window sample store: one slot per (channel, window position).
// Storage is not reset; slot validity is tracked by the caller's fill counters.
module xmpl_dsp_msf_win_ram #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: store the newest sample over the oldest slot
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < 32'(DEPTH))) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read port, out-of-range addresses read as zero
    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < 32'(DEPTH)) begin
            rd_data = mem_r[rd_addr];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/xmpl_dsp_msf_mc.sv
// Multi-channel moving-sum filter. Samples arrive tagged with a channel index;
// each accepted sample returns that channel's sum over its last WIN_LEN samples.
// Optional feature macro: XMPL_DSP_MSF_MEAN_EN adds a registered window-mean output.
module xmpl_dsp_msf_mc
    import xmpl_dsp_msf_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 12,
    parameter int WIN_LEN = 8,
    parameter int OUT_W   = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              xmpl_dsp_msf_en_i,
    input  logic              xmpl_dsp_msf_clr_i,
    input  logic              xmpl_dsp_msf_valid_i,
    output logic              xmpl_dsp_msf_ready_o,
    input  logic [CH_W-1:0]   xmpl_dsp_msf_ch_i,
    input  logic [DATA_W-1:0] xmpl_dsp_msf_data_i,
    output logic              xmpl_dsp_msf_valid_o,
    input  logic              xmpl_dsp_msf_ready_i,
    output logic [CH_W-1:0]   xmpl_dsp_msf_ch_o,
    output logic [OUT_W-1:0]  xmpl_dsp_msf_sum_o,
`ifdef XMPL_DSP_MSF_MEAN_EN
    output logic [DATA_W-1:0] xmpl_dsp_msf_mean_o,
`endif
    output logic [OUT_W-1:0]  xmpl_dsp_msf_status_o
);

    localparam int PTR_W  = $clog2(WIN_LEN);
    localparam int ACC_W  = DATA_W + PTR_W;
    localparam int FILL_W = PTR_W + 1;
    localparam int ADDR_W = CH_W + PTR_W;
    localparam int DEPTH  = NUM_CH * WIN_LEN;

    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIN_LEN);
    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(WIN_LEN - 1);

    // Parameter legality
    if (ACC_W > OUT_W) begin : g_err_acc_w
        $error("xmpl_dsp_msf_mc: ACC_W exceeds OUT_W");
    end
    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_err_num_ch
        $error("xmpl_dsp_msf_mc: NUM_CH must be 1..16");
    end
    if (!is_pow2(WIN_LEN) || (WIN_LEN < 2) || (WIN_LEN > 256)) begin : g_err_win_len
        $error("xmpl_dsp_msf_mc: WIN_LEN must be a power of two in 2..256");
    end

    // Control state
    msf_state_e                state_r;
    msf_state_e                state_nxt_s;
    logic                      ready_r;
    logic                      accept_s;
    logic [CH_W-1:0]           cap_ch_r;
    logic signed [DATA_W-1:0]  cap_data_r;

    // Per-channel state
    logic signed [ACC_W-1:0]   acc_r  [NUM_CH];
    logic [PTR_W-1:0]          wptr_r [NUM_CH];
    logic [FILL_W-1:0]         fill_r [NUM_CH];
    logic [CNT_W-1:0]          cnt_r;

    // Update datapath
    logic                      ch_ok_s;
    logic [CH_W-1:0]           ch_idx_s;
    logic [PTR_W-1:0]          wptr_cur_s;
    logic [PTR_W-1:0]          wptr_new_s;
    logic [FILL_W-1:0]         fill_cur_s;
    logic [FILL_W-1:0]         fill_new_s;
    logic                      full_cur_s;
    logic [DATA_W-1:0]         rd_data_s;
    logic signed [DATA_W-1:0]  old_s;
    logic signed [ACC_W-1:0]   acc_new_s;
    logic                      do_upd_s;
    logic [CNT_W-1:0]          cnt_nxt_s;
    logic [NUM_CH-1:0]         full_nxt_s;
    logic [31:0]               status32_s;

    // Registered outputs
    logic                      valid_r;
    logic [CH_W-1:0]           ch_out_r;
    logic [OUT_W-1:0]          sum_r;
    logic [OUT_W-1:0]          status_r;
`ifdef XMPL_DSP_MSF_MEAN_EN
    logic signed [ACC_W-1:0]   mean_full_s;
    logic [DATA_W-1:0]         mean_new_s;
    logic [DATA_W-1:0]         mean_r;
`endif

    // ready_r is only ever set while the next state is IDLE
    assign accept_s = xmpl_dsp_msf_valid_i && ready_r && (state_r == IDLE);

    // Next-state logic; clear forces IDLE
    always_comb begin
        state_nxt_s = state_r;
        if (xmpl_dsp_msf_clr_i) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = UPD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                UPD: begin
                    if (ch_ok_s) begin
                        state_nxt_s = OUT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                OUT: begin
                    if (xmpl_dsp_msf_ready_i) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = OUT;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register, input ready and sample capture
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= IDLE;
            ready_r    <= 1'b0;
            cap_ch_r   <= '0;
            cap_data_r <= '0;
        end else if (xmpl_dsp_msf_clr_i) begin
            state_r    <= IDLE;
            ready_r    <= xmpl_dsp_msf_en_i;
            cap_ch_r   <= '0;
            cap_data_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= xmpl_dsp_msf_en_i && (state_nxt_s == IDLE);
            if (accept_s) begin
                cap_ch_r   <= xmpl_dsp_msf_ch_i;
                cap_data_r <= xmpl_dsp_msf_data_i;
            end
        end
    end

    // Window update arithmetic for the captured channel
    always_comb begin
        ch_ok_s    = ({1'b0, cap_ch_r} < NUM_CH_L);
        ch_idx_s   = ch_ok_s ? cap_ch_r : '0;
        wptr_cur_s = wptr_r[ch_idx_s];
        fill_cur_s = fill_r[ch_idx_s];
        full_cur_s = (fill_cur_s == FILL_MAX);
        // The slot about to be overwritten holds the oldest sample once full
        if (full_cur_s) begin
            old_s      = rd_data_s;
            fill_new_s = fill_cur_s;
        end else begin
            old_s      = '0;
            fill_new_s = fill_cur_s + FILL_W'(1);
        end
        if (wptr_cur_s == PTR_MAX) begin
            wptr_new_s = '0;
        end else begin
            wptr_new_s = wptr_cur_s + PTR_W'(1);
        end
        acc_new_s = acc_r[ch_idx_s] + ACC_W'(cap_data_r) - ACC_W'(old_s);
        do_upd_s  = (state_r == UPD) && ch_ok_s && !xmpl_dsp_msf_clr_i;
        if (do_upd_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Status word as it will look after the coming edge
    always_comb begin
        full_nxt_s = '0;
        status32_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full_nxt_s[c] = (fill_r[c] == FILL_MAX) ||
                            (do_upd_s && (ch_idx_s == CH_W'(c)) && (fill_new_s == FILL_MAX));
            status32_s[FULL_LSB + c] = full_nxt_s[c];
        end
        status32_s[CNT_LSB +: CNT_W] = cnt_nxt_s;
        status32_s[BUSY_BIT]         = (state_nxt_s != IDLE);
    end

`ifdef XMPL_DSP_MSF_MEAN_EN
    // Window mean: arithmetic shift rounds toward minus infinity
    always_comb begin
        mean_full_s = acc_new_s >>> PTR_W;
        mean_new_s  = mean_full_s[DATA_W-1:0];
    end
`endif

    // Per-channel accumulators, write pointers, fill levels and sample counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_r[c]  <= '0;
                wptr_r[c] <= '0;
                fill_r[c] <= '0;
            end
            cnt_r <= '0;
        end else if (xmpl_dsp_msf_clr_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_r[c]  <= '0;
                wptr_r[c] <= '0;
                fill_r[c] <= '0;
            end
            cnt_r <= '0;
        end else if (do_upd_s) begin
            acc_r[ch_idx_s]  <= acc_new_s;
            wptr_r[ch_idx_s] <= wptr_new_s;
            fill_r[ch_idx_s] <= fill_new_s;
            cnt_r            <= cnt_nxt_s;
        end
    end

    // Result and status registers; result held until the consumer takes it
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_r  <= 1'b0;
            ch_out_r <= '0;
            sum_r    <= '0;
            status_r <= '0;
`ifdef XMPL_DSP_MSF_MEAN_EN
            mean_r   <= '0;
`endif
        end else if (xmpl_dsp_msf_clr_i) begin
            valid_r  <= 1'b0;
            ch_out_r <= '0;
            sum_r    <= '0;
            status_r <= '0;
`ifdef XMPL_DSP_MSF_MEAN_EN
            mean_r   <= '0;
`endif
        end else begin
            status_r <= OUT_W'(status32_s);
            if (do_upd_s) begin
                valid_r  <= 1'b1;
                ch_out_r <= cap_ch_r;
                sum_r    <= OUT_W'(acc_new_s);
`ifdef XMPL_DSP_MSF_MEAN_EN
                mean_r   <= mean_new_s;
`endif
            end else if ((state_r == OUT) && xmpl_dsp_msf_ready_i) begin
                valid_r <= 1'b0;
            end
        end
    end

    xmpl_dsp_msf_win_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_win_ram (
        .clk     (clk_i),
        .wr_en   (do_upd_s),
        .wr_addr ({ch_idx_s, wptr_cur_s}),
        .wr_data (cap_data_r),
        .rd_addr ({ch_idx_s, wptr_cur_s}),
        .rd_data (rd_data_s)
    );

    assign xmpl_dsp_msf_ready_o  = ready_r;
    assign xmpl_dsp_msf_valid_o  = valid_r;
    assign xmpl_dsp_msf_ch_o     = ch_out_r;
    assign xmpl_dsp_msf_sum_o    = sum_r;
    assign xmpl_dsp_msf_status_o = status_r;
`ifdef XMPL_DSP_MSF_MEAN_EN
    assign xmpl_dsp_msf_mean_o   = mean_r;
`endif

endmodule
